alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
Registered, handshaked ALU control decoder for the KGP-RISC execute stage. It maps the instruction function code to the ALU control field, using the same table as the current combinational decoder. It adds an iterative-shift mode in which one shift instruction is issued to the ALU as a train of 1-bit shift beats. The block sits between the instruction decode register and the ALU operand stage.

Parameters:
FUNC_W, 3, function-code width; codes above 3'b101 (zero-extended) decode to the default class.
CTRL_W, 2, ALU control width; must be >= 2.
SHAMT_W, 5, shift-amount width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  request present
in_ready  out  1  block can accept this cycle
func  in  FUNC_W  function code
shamt  in  SHAMT_W  shift amount
iter_mode  in  1  1 = split shift ops into 1-bit beats
out_valid  out  1  beat present
out_ready  in  1  ALU consumes the beat
alu_ctrl  out  CTRL_W  decoded ALU control
step_amt  out  SHAMT_W  shift amount for this beat
out_last  out  1  final beat of the instruction
busy  out  1  an instruction is in flight

Behaviour:
- Clocking: single clock clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Decode table, zero-extended to CTRL_W:
  - func==3 -> 01
  - func==4 -> 10
  - func==5 -> 11
  - all other codes -> 00
- Shift class: alu_ctrl 10 and 11. All other classes are single-beat.
- States: IDLE, SINGLE, ITER.
- Accept: in_fire = in_valid & in_ready. func, shamt and iter_mode are sampled only at in_fire; later input changes are ignored.
- in_ready = 0 while rst is high. Otherwise in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This gives a back-to-back path with a combinational dependence on out_ready. There is no combinational path from in_valid to any output.
- Latency: a request accepted at edge k presents its first beat (out_valid=1) after edge k.
- On accept, the next state is chosen as follows:
  - Non-shift class, or iter_mode=0 -> SINGLE. One beat with step_amt=shamt and out_last=1.
  - Shift class, iter_mode=1, shamt==0 -> SINGLE. One beat with step_amt=0 and out_last=1.
  - Shift class, iter_mode=1, shamt>0 -> ITER. Counter rem loads shamt. Each beat has step_amt=1 and out_last=(rem==1).
- Beat advance happens on out_valid & out_ready.
  - In ITER, rem decrements by one per advance.
  - The last beat returns the block to IDLE, or reloads directly if in_fire occurs in the same cycle.
- Stall: while out_ready=0, all outputs hold their values exactly and rem is frozen.
- Beat count per instruction: exactly shamt beats, or 1 if shamt==0 or not iterated. Maximum is 2^SHAMT_W-1 (31).
- alu_ctrl is constant across every beat of one instruction.
- busy = (state != IDLE).
- Reset, including mid-instruction: on the next edge, state=IDLE, rem=0, out_valid=0, alu_ctrl=0, step_amt=0, out_last=0, busy=0. The train is aborted and no further beats are emitted.
- Simultaneous rst and in_valid: reset wins and the request is not accepted.

Decomposition:
- Shared package alu_pkg holds:
  - function-code constants FN_3, FN_4, FN_5
  - ALU control constants CTRL_DEF, CTRL_01, CTRL_SH_A, CTRL_SH_B
  - state encoding IDLE, SINGLE, ITER
  - function is_shift_ctrl()
- Sub-module alu_func_dec: purely combinational mapping from func to alu_ctrl, parametrised on FUNC_W and CTRL_W. It is instantiated once, before the sampling register.

Test Plan:
- Reset, then func=3, iter_mode=0, out_ready=1 -> one beat with alu_ctrl=01, step_amt=shamt, out_last=1; busy drops the following cycle.
- func=4, shamt=3, iter_mode=1 -> three beats with alu_ctrl=10, step_amt=1, out_last=0,0,1; in_ready=0 until the third beat fires.
- func=5, shamt=0, iter_mode=1 -> single beat with alu_ctrl=11, step_amt=0, out_last=1.
- func=4, shamt=2, iter_mode=1, out_ready held low 4 cycles on beat 1 -> outputs stable throughout the stall; exactly 2 beats total.
- Back-to-back: func=4/shamt=1 then func=0 with in_valid held -> second accepted on the same edge the first's last beat fires; next cycle alu_ctrl=00; func=7 -> 00.
- rst asserted after beat 2 of a shamt=5 train -> next cycle out_valid=0, busy=0, in_ready=1; no residual beats afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants, state encoding and class helper for the ALU control sequencer.
package alu_pkg;

  localparam int unsigned FN_3 = 3;
  localparam int unsigned FN_4 = 4;
  localparam int unsigned FN_5 = 5;

  localparam logic [1:0] CTRL_DEF  = 2'b00;
  localparam logic [1:0] CTRL_01   = 2'b01;
  localparam logic [1:0] CTRL_SH_A = 2'b10;
  localparam logic [1:0] CTRL_SH_B = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    ITER   = 2'd2
  } state_t;

  // Both shift controls share the upper code bit; every other class is single-beat.
  function automatic logic is_shift_ctrl(input logic [1:0] ctrl);
    return (ctrl == CTRL_SH_A) || (ctrl == CTRL_SH_B);
  endfunction

endpackage

// File: rtl/alu_func_dec.sv
// Combinational function-code to ALU-control table; unknown codes fall to the default class.
module alu_func_dec import alu_pkg::*; #(
  parameter int FUNC_W = 3,
  parameter int CTRL_W = 2
) (
  input  logic [FUNC_W-1:0] func,
  output logic [CTRL_W-1:0] alu_ctrl
);

  // Zero-extended compare so narrow or wide function fields map the same way.
  always_comb begin
    alu_ctrl = CTRL_W'(CTRL_DEF);
    case (32'(func))
      FN_3:    alu_ctrl = CTRL_W'(CTRL_01);
      FN_4:    alu_ctrl = CTRL_W'(CTRL_SH_A);
      FN_5:    alu_ctrl = CTRL_W'(CTRL_SH_B);
      default: alu_ctrl = CTRL_W'(CTRL_DEF);
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control decoder; optionally splits a shift into 1-bit beats.
module alu_ctrl_seq import alu_pkg::*; #(
  parameter int FUNC_W  = 3,
  parameter int CTRL_W  = 2,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNC_W-1:0]  func,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               iter_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic [SHAMT_W-1:0] step_amt,
  output logic               out_last,
  output logic               busy
);

  logic [CTRL_W-1:0]  dec_ctrl_p0;
  state_t             state_p1, state_nxt;
  logic [SHAMT_W-1:0] rem_p1, rem_nxt, step_nxt;
  logic [CTRL_W-1:0]  ctrl_nxt;
  logic               last_nxt;
  logic               adv, in_fire, iter_go;

  alu_func_dec #(
    .FUNC_W (FUNC_W),
    .CTRL_W (CTRL_W)
  ) u_dec (
    .func     (func),
    .alu_ctrl (dec_ctrl_p0)
  );

  // A beat is on the output whenever an instruction is in flight.
  assign out_valid = (state_p1 != IDLE);
  assign busy      = (state_p1 != IDLE);
  assign adv       = out_valid & out_ready;
  // Accept when idle, or on the cycle the last beat leaves (back-to-back path).
  assign in_ready  = !rst && ((state_p1 == IDLE) || (adv && out_last));
  assign in_fire   = in_valid & in_ready;
  assign iter_go   = iter_mode && is_shift_ctrl(dec_ctrl_p0[1:0]) && (shamt != '0);

  // Next-state and next-beat selection; everything holds unless a beat advances or a request lands.
  always_comb begin
    state_nxt = state_p1;
    rem_nxt   = rem_p1;
    ctrl_nxt  = alu_ctrl;
    step_nxt  = step_amt;
    last_nxt  = out_last;
    if (in_fire) begin
      ctrl_nxt = dec_ctrl_p0;
      if (iter_go) begin
        state_nxt = ITER;
        rem_nxt   = shamt;
        step_nxt  = SHAMT_W'(1);
        last_nxt  = (shamt == SHAMT_W'(1));
      end else begin
        state_nxt = SINGLE;
        rem_nxt   = '0;
        step_nxt  = shamt;
        last_nxt  = 1'b1;
      end
    end else if (adv) begin
      if ((state_p1 == ITER) && !out_last) begin
        rem_nxt  = rem_p1 - SHAMT_W'(1);
        last_nxt = (rem_p1 == SHAMT_W'(2));
      end else begin
        state_nxt = IDLE;
        rem_nxt   = '0;
        ctrl_nxt  = '0;
        step_nxt  = '0;
        last_nxt  = 1'b0;
      end
    end
  end

  // Stage p1: state, remaining-beat counter and the presented beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= IDLE;
      rem_p1   <= '0;
      alu_ctrl <= '0;
      step_amt <= '0;
      out_last <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      rem_p1   <= rem_nxt;
      alu_ctrl <= ctrl_nxt;
      step_amt <= step_nxt;
      out_last <= last_nxt;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench: directed scenarios plus randomized traffic against a beat-queue model.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, iter_mode, out_valid, out_ready, out_last, busy;
  logic [2:0] func;
  logic [4:0] shamt, step_amt;
  logic [1:0] alu_ctrl;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] ctrl;
    logic [4:0] step;
    logic       last;
  } beat_t;

  beat_t q[$];

  alu_ctrl_seq #(.FUNC_W(3), .CTRL_W(2), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .shamt     (shamt),
    .iter_mode (iter_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .step_amt  (step_amt),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] ref_ctrl(input logic [2:0] f);
    case (f)
      3'd3:    return 2'b01;
      3'd4:    return 2'b10;
      3'd5:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; func = 3'd3; shamt = 5'd4; iter_mode = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (alu_ctrl !== 2'b00) begin errors++; $display("FAIL rst_alu_ctrl: got %b want 00", alu_ctrl); end
    checks++; if (step_amt !== 5'd0) begin errors++; $display("FAIL rst_step: got %0d want 0", step_amt); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", out_last); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; func = 3'd3; shamt = 5'd9; iter_mode = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (alu_ctrl !== 2'b01) begin errors++; $display("FAIL single_ctrl: got %b want 01", alu_ctrl); end
    checks++; if (step_amt !== 5'd9) begin errors++; $display("FAIL single_step: got %0d want 9", step_amt); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL single_last: got %b want 1", out_last); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_done_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done_busy: got %b want 0", busy); end
  endtask

  task automatic test_iter();
    in_valid = 1'b1; func = 3'd4; shamt = 5'd3; iter_mode = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    for (int b = 0; b < 3; b++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL iter_valid[%0d]: got %b want 1", b, out_valid); end
      checks++; if (alu_ctrl !== 2'b10) begin errors++; $display("FAIL iter_ctrl[%0d]: got %b want 10", b, alu_ctrl); end
      checks++; if (step_amt !== 5'd1) begin errors++; $display("FAIL iter_step[%0d]: got %0d want 1", b, step_amt); end
      checks++; if (out_last !== (b == 2)) begin errors++; $display("FAIL iter_last[%0d]: got %b want %b", b, out_last, (b == 2)); end
      checks++; if (in_ready !== (b == 2)) begin errors++; $display("FAIL iter_ready[%0d]: got %b want %b", b, in_ready, (b == 2)); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL iter_done: got %b want 0", out_valid); end
  endtask

  task automatic test_zero_shift();
    in_valid = 1'b1; func = 3'd5; shamt = 5'd0; iter_mode = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %b want 1", out_valid); end
    checks++; if (alu_ctrl !== 2'b11) begin errors++; $display("FAIL zero_ctrl: got %b want 11", alu_ctrl); end
    checks++; if (step_amt !== 5'd0) begin errors++; $display("FAIL zero_step: got %0d want 0", step_amt); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL zero_last: got %b want 1", out_last); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_done: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    int count;
    in_valid = 1'b1; func = 3'd4; shamt = 5'd2; iter_mode = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (step_amt !== 5'd1 || out_last !== 1'b0 || alu_ctrl !== 2'b10)
      begin errors++; $display("FAIL stall_first: got ctrl=%b step=%0d last=%b want ctrl=10 step=1 last=0", alu_ctrl, step_amt, out_last); end
    repeat (4) begin
      tick();
      checks++; if (out_valid !== 1'b1 || alu_ctrl !== 2'b10 || step_amt !== 5'd1 || out_last !== 1'b0 || in_ready !== 1'b0)
        begin errors++; $display("FAIL stall_hold: got v=%b ctrl=%b step=%0d last=%b rdy=%b want v=1 ctrl=10 step=1 last=0 rdy=0",
                                 out_valid, alu_ctrl, step_amt, out_last, in_ready); end
    end
    out_ready = 1'b1;
    count = 0;
    for (int i = 0; i < 10; i++) begin
      if (!out_valid) break;
      count++;
      tick();
    end
    checks++; if (count != 2) begin errors++; $display("FAIL stall_beats: got %0d want 2", count); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; func = 3'd4; shamt = 5'd1; iter_mode = 1'b1; out_ready = 1'b1;
    tick();
    func = 3'd0; shamt = 5'd6; iter_mode = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_last !== 1'b1 || alu_ctrl !== 2'b10)
      begin errors++; $display("FAIL b2b_first: got rdy=%b last=%b ctrl=%b want rdy=1 last=1 ctrl=10", in_ready, out_last, alu_ctrl); end
    tick();
    checks++; if (out_valid !== 1'b1 || alu_ctrl !== 2'b00 || step_amt !== 5'd6 || out_last !== 1'b1)
      begin errors++; $display("FAIL b2b_second: got v=%b ctrl=%b step=%0d last=%b want v=1 ctrl=00 step=6 last=1", out_valid, alu_ctrl, step_amt, out_last); end
    func = 3'd7; shamt = 5'd2; iter_mode = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || alu_ctrl !== 2'b00 || step_amt !== 5'd2 || out_last !== 1'b1)
      begin errors++; $display("FAIL b2b_func7: got v=%b ctrl=%b step=%0d last=%b want v=1 ctrl=00 step=2 last=1", out_valid, alu_ctrl, step_amt, out_last); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_done: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; func = 3'd4; shamt = 5'd5; iter_mode = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b1 || step_amt !== 5'd1 || out_last !== 1'b0)
      begin errors++; $display("FAIL rmid_beat3: got v=%b step=%0d last=%b want v=1 step=1 last=0", out_valid, step_amt, out_last); end
    rst = 1'b1; in_valid = 1'b1; func = 3'd3; iter_mode = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_rst: got %b want 0", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || alu_ctrl !== 2'b00 || step_amt !== 5'd0 || out_last !== 1'b0)
      begin errors++; $display("FAIL rmid_cleared: got v=%b busy=%b ctrl=%b step=%0d last=%b want all 0", out_valid, busy, alu_ctrl, step_amt, out_last); end
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
    repeat (5) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_residual: got %b want 0", out_valid); end
    end
  endtask

  task automatic test_random();
    beat_t b;
    logic  exp_ready;
    int    n;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      func      = 3'($urandom_range(0, 7));
      shamt     = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
      iter_mode = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_ready = (q.size() == 0) || (out_ready && q.size() == 1);
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, in_ready, exp_ready); end
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, out_valid, (q.size() != 0)); end
      checks++; if (busy !== (q.size() != 0)) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, (q.size() != 0)); end
      if (out_valid === 1'b1 && q.size() > 0) begin
        checks++;
        if (alu_ctrl !== q[0].ctrl || step_amt !== q[0].step || out_last !== q[0].last) begin
          errors++;
          $display("FAIL rnd_beat@%0d: got ctrl=%b step=%0d last=%b want ctrl=%b step=%0d last=%b",
                   cyc, alu_ctrl, step_amt, out_last, q[0].ctrl, q[0].step, q[0].last);
        end
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && exp_ready) begin
        b.ctrl = ref_ctrl(func);
        if (b.ctrl[1] && iter_mode && shamt != 0) begin
          n = shamt;
          for (int k = 1; k <= n; k++) begin
            b.step = 5'd1;
            b.last = (k == n);
            q.push_back(b);
          end
        end else begin
          b.step = shamt;
          b.last = 1'b1;
          q.push_back(b);
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (out_valid !== 1'b1) break;
      if (q.size() > 0) begin
        checks++;
        if (alu_ctrl !== q[0].ctrl || step_amt !== q[0].step || out_last !== q[0].last) begin
          errors++;
          $display("FAIL drain_beat: got ctrl=%b step=%0d last=%b want ctrl=%b step=%0d last=%b",
                   alu_ctrl, step_amt, out_last, q[0].ctrl, q[0].step, q[0].last);
        end
        void'(q.pop_front());
      end
      tick();
    end
    checks++; if (q.size() != 0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL drain_end: got pending=%0d valid=%b want pending=0 valid=0", q.size(), out_valid); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; func = '0; shamt = '0; iter_mode = 1'b0; out_ready = 1'b1;
    test_reset();
    test_single();
    test_iter();
    test_zero_shift();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
